modn_updown_counter_prog: RTL and testbench
===========================================

// Module: modn_updown_counter_prog
// PURPOSE
//  Mod-N up/down counter, generalised: modulus reprogrammable at runtime,
//  per-cycle step size, synchronous load, count enable, registered wrap pulse.
//  Used as a programmable divider/sequencer or timebase inside datapath blocks.
//  Successor to the fixed-N, step-1 up/down counter.
// PARAMETERS
//  WIDTH    4   count width; modulus range 2..2**WIDTH
//  N_RESET  10  modulus after reset; must satisfy 2 <= N_RESET <= 2**WIDTH
// PORTS
//  clk       in   1        rising-edge clock, the block's only clock
//  reset     in   1        asynchronous, active-low reset
//  en        in   1        count enable
//  upordown  in   1        1 = count up, 0 = count down
//  step      in   WIDTH    increment/decrement amount per enabled cycle
//  load      in   1        synchronous load of load_val into count
//  load_val  in   WIDTH    load value
//  mod_wr    in   1        write new modulus
//  mod_val   in   WIDTH+1  new modulus
//  count     out  WIDTH    current count, always < mod_cur
//  mod_cur   out  WIDTH+1  active modulus
//  wrap      out  1        1-cycle pulse: the last update crossed the modulus boundary
//  cfg_err   out  1        1-cycle pulse: the last request was rejected
// BEHAVIOUR
//  - Reset (reset=0, asynchronous, immediate): count=0, mod_cur=N_RESET,
//    wrap=0, cfg_err=0. Normal operation resumes on the first clk edge after release.
//  - All outputs registered. wrap and cfg_err are valid in the same cycle as
//    the count update they describe, and are 0 in every other cycle.
//  - Priority per edge: mod_wr > load > en. Lower-priority requests in the
//    same cycle are dropped silently.
//  - mod_wr: if 2 <= mod_val <= 2**WIDTH, then mod_cur <= mod_val.
//    count is kept if count < mod_val, else count <= 0. wrap=0.
//    If mod_val is out of range: no change, cfg_err=1.
//  - load (no mod_wr): if load_val < mod_cur, then count <= load_val.
//    Otherwise count is held and cfg_err=1. wrap=0.
//  - en (no mod_wr/load):
//    step == 0: hold, wrap=0.
//    step >= mod_cur: hold, cfg_err=1.
//    up:   s = count + step, computed in WIDTH+2 bits.
//          If s >= mod_cur: count <= s - mod_cur, wrap=1. Else count <= s.
//    down: if count >= step: count <= count - step.
//          Else count <= count + mod_cur - step, wrap=1.
//  - en=0 and no request: count holds, pulses 0.
//  - upordown may change on any cycle; it is sampled only on enabled edges.
//  - Invariant: count < mod_cur on every cycle.
// STRUCTURE
//  - Shared package modn_pkg:
//    DIR_UP=1'b1, DIR_DN=1'b0; function modn_valid(mod, width) for the range check.
//  - One sub-module, modn_step_core: combinational next-count and wrap from
//    (count, step, mod_cur, upordown).
//  - The top level holds the registers, the priority mux and the range checks.
//  - Elaboration-time check on N_RESET.
// TESTING  (WIDTH=4, N_RESET=10)
//  1. Release reset; en=1, up, step=1, 12 edges -> count 1..9,0,1,2.
//     wrap=1 only on the 9->0 edge.
//  2. load 2, then down, step=3 -> count=9, wrap=1.
//     Next edge -> 6, wrap=0.
//  3. count=7, mod_wr 16 -> mod_cur=16, count=7.
//     Then up, step=15 -> count=6, wrap=1.
//  4. count=7, mod_wr 5 -> count=0, mod_cur=5.
//     mod_wr 1 -> cfg_err=1, mod_cur stays 5.
//     mod_wr 17 -> cfg_err=1.
//  5. mod_cur=10: load 12 -> cfg_err=1, count held.
//     load 4 with en=1 in the same cycle -> count=4, no step applied.
//     en with step=10 -> hold, cfg_err=1.
//  6. Drive reset=0 mid-count, between edges -> count=0 and mod_cur=10
//    immediately, no clk needed; pulses 0.
//    mod_wr+load in the same cycle -> only the modulus changes.

Source files
------------

// File: rtl/modn_pkg.sv
// Shared definitions for the programmable mod-N counter family:
// direction encodings and the modulus range check.
package modn_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // A modulus is usable when 2 <= mod <= 2**width.
  function automatic logic modn_valid(input logic [31:0] mod, input int width);
    logic [32:0] limit;
    limit = 33'd1 << width;
    return (mod >= 32'd2) && ({1'b0, mod} <= limit);
  endfunction

endpackage

// File: rtl/modn_step_core.sv
// Combinational next-count for one enabled step, up or down, modulo mod_cur.
// Assumes count < mod_cur and step < mod_cur; the caller screens other cases.
module modn_step_core
  import modn_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH:0]   mod_cur,
  input  logic             upordown,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap
);

  logic [WIDTH+1:0] cnt_ext;
  logic [WIDTH+1:0] step_ext;
  logic [WIDTH+1:0] mod_ext;
  logic [WIDTH+1:0] res;

  assign cnt_ext  = {2'b00, count};
  assign step_ext = {2'b00, step};
  assign mod_ext  = {1'b0, mod_cur};

  // Extra headroom bits keep count + step and count + mod_cur free of overflow.
  always_comb begin
    res  = cnt_ext;
    wrap = 1'b0;
    if (upordown == DIR_UP) begin
      res = cnt_ext + step_ext;
      if (res >= mod_ext) begin
        res  = res - mod_ext;
        wrap = 1'b1;
      end
    end else begin
      if (cnt_ext >= step_ext) begin
        res = cnt_ext - step_ext;
      end else begin
        res  = cnt_ext + mod_ext - step_ext;
        wrap = 1'b1;
      end
    end
  end

  assign next_count = res[WIDTH-1:0];

endmodule

// File: rtl/modn_updown_counter_prog.sv
// Mod-N up/down counter with runtime modulus, per-cycle step, synchronous load
// and registered wrap / configuration-error pulses.
module modn_updown_counter_prog
  import modn_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int N_RESET = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             upordown,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH:0]   mod_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH:0]   mod_cur,
  output logic             wrap,
  output logic             cfg_err
);

  localparam logic [WIDTH:0] MOD_RESET = (WIDTH+1)'(N_RESET);

  generate
    if (!modn_valid(32'(N_RESET), WIDTH)) begin : g_bad_n_reset
      $error("modn_updown_counter_prog: N_RESET must lie in 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] core_next;
  logic             core_wrap;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH:0]   mod_nxt;
  logic             wrap_nxt;
  logic             err_nxt;

  modn_step_core #(.WIDTH(WIDTH)) u_step_core (
    .count      (count),
    .step       (step),
    .mod_cur    (mod_cur),
    .upordown   (upordown),
    .next_count (core_next),
    .wrap       (core_wrap)
  );

  // Priority is mod_wr > load > en; a losing request is simply ignored.
  always_comb begin
    count_nxt = count;
    mod_nxt   = mod_cur;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (mod_wr) begin
      if (modn_valid(32'(mod_val), WIDTH)) begin
        mod_nxt = mod_val;
        if ({1'b0, count} >= mod_val) begin
          count_nxt = '0;
        end
      end else begin
        err_nxt = 1'b1;
      end
    end else if (load) begin
      if ({1'b0, load_val} < mod_cur) begin
        count_nxt = load_val;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (step == '0) begin
        count_nxt = count;
      end else if ({1'b0, step} >= mod_cur) begin
        err_nxt = 1'b1;
      end else begin
        count_nxt = core_next;
        wrap_nxt  = core_wrap;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      mod_cur <= MOD_RESET;
      wrap    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      count   <= count_nxt;
      mod_cur <= mod_nxt;
      wrap    <= wrap_nxt;
      cfg_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_modn_updown_counter_prog.sv
// Directed bench for modn_updown_counter_prog (WIDTH=4, N_RESET=10): a vector
// table of per-edge requests with hand-computed results, plus reset sequences.
module tb_modn_updown_counter_prog;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic             upordown;
  logic [WIDTH-1:0] step;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             mod_wr;
  logic [WIDTH:0]   mod_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   mod_cur;
  logic             wrap;
  logic             cfg_err;

  int checks;
  int fails;

  typedef struct {
    string            name;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] step;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             mod_wr;
    logic [WIDTH:0]   mod_val;
    logic [WIDTH-1:0] exp_count;
    logic [WIDTH:0]   exp_mod;
    logic             exp_wrap;
    logic             exp_err;
  } vec_t;

  vec_t vecs[$];

  modn_updown_counter_prog #(.WIDTH(WIDTH), .N_RESET(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .upordown (upordown),
    .step     (step),
    .load     (load),
    .load_val (load_val),
    .mod_wr   (mod_wr),
    .mod_val  (mod_val),
    .count    (count),
    .mod_cur  (mod_cur),
    .wrap     (wrap),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic e, input logic u,
                              input int st, input logic ld, input int lv,
                              input logic mw, input int mv, input int ec,
                              input int em, input logic ew, input logic ee);
    vec_t v;
    v.name      = name;
    v.en        = e;
    v.up        = u;
    v.step      = WIDTH'(st);
    v.load      = ld;
    v.load_val  = WIDTH'(lv);
    v.mod_wr    = mw;
    v.mod_val   = (WIDTH+1)'(mv);
    v.exp_count = WIDTH'(ec);
    v.exp_mod   = (WIDTH+1)'(em);
    v.exp_wrap  = ew;
    v.exp_err   = ee;
    return v;
  endfunction

  task automatic apply_stimulus(input logic e, input logic u, input logic [WIDTH-1:0] st,
                                input logic ld, input logic [WIDTH-1:0] lv,
                                input logic mw, input logic [WIDTH:0] mv);
    en       = e;
    upordown = u;
    step     = st;
    load     = ld;
    load_val = lv;
    mod_wr   = mw;
    mod_val  = mv;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input int ec, input int em,
                           input logic ew, input logic ee);
    check_output({name, " count"},   32'(count),   32'(ec));
    check_output({name, " mod_cur"}, 32'(mod_cur), 32'(em));
    check_output({name, " wrap"},    32'(wrap),    32'(ew));
    check_output({name, " cfg_err"}, 32'(cfg_err), 32'(ee));
  endtask

  initial begin
    checks = 0;
    fails  = 0;

    // Counting up by one from reset: 1..9, wrap to 0, then 1, 2.
    for (int i = 1; i <= 12; i++) begin
      vecs.push_back(mk($sformatf("up1_%0d", i), 1, 1, 1, 0, 0, 0, 0,
                        i % 10, 10, (i == 10), 0));
    end
    vecs.push_back(mk("idle_hold",     0, 0, 3, 0, 0, 0, 0,  2, 10, 0, 0));
    vecs.push_back(mk("load2",         0, 0, 0, 1, 2, 0, 0,  2, 10, 0, 0));
    vecs.push_back(mk("down3_wrap",    1, 0, 3, 0, 0, 0, 0,  9, 10, 1, 0));
    vecs.push_back(mk("down3",         1, 0, 3, 0, 0, 0, 0,  6, 10, 0, 0));
    vecs.push_back(mk("load7",         0, 0, 0, 1, 7, 0, 0,  7, 10, 0, 0));
    vecs.push_back(mk("mod16_keep",    0, 0, 0, 0, 0, 1, 16, 7, 16, 0, 0));
    vecs.push_back(mk("up15_wrap",     1, 1, 15, 0, 0, 0, 0, 6, 16, 1, 0));
    vecs.push_back(mk("load7b",        0, 0, 0, 1, 7, 0, 0,  7, 16, 0, 0));
    vecs.push_back(mk("mod5_clear",    0, 0, 0, 0, 0, 1, 5,  0, 5, 0, 0));
    vecs.push_back(mk("mod1_reject",   0, 0, 0, 0, 0, 1, 1,  0, 5, 0, 1));
    vecs.push_back(mk("mod17_reject",  0, 0, 0, 0, 0, 1, 17, 0, 5, 0, 1));
    vecs.push_back(mk("mod10",         0, 0, 0, 0, 0, 1, 10, 0, 10, 0, 0));
    vecs.push_back(mk("load3",         0, 0, 0, 1, 3, 0, 0,  3, 10, 0, 0));
    vecs.push_back(mk("load12_reject", 0, 0, 0, 1, 12, 0, 0, 3, 10, 0, 1));
    vecs.push_back(mk("load4_over_en", 1, 1, 1, 1, 4, 0, 0,  4, 10, 0, 0));
    vecs.push_back(mk("step10_reject", 1, 1, 10, 0, 0, 0, 0, 4, 10, 0, 1));
    vecs.push_back(mk("step0_hold",    1, 1, 0, 0, 0, 0, 0,  4, 10, 0, 0));
    vecs.push_back(mk("load10_reject", 0, 0, 0, 1, 10, 0, 0, 4, 10, 0, 1));
    vecs.push_back(mk("load9_edge",    0, 0, 0, 1, 9, 0, 0,  9, 10, 0, 0));
    vecs.push_back(mk("up9_wrap",      1, 1, 9, 0, 0, 0, 0,  8, 10, 1, 0));
    vecs.push_back(mk("down9_wrap",    1, 0, 9, 0, 0, 0, 0,  9, 10, 1, 0));
    vecs.push_back(mk("down9_exact",   1, 0, 9, 0, 0, 0, 0,  0, 10, 0, 0));
    vecs.push_back(mk("mod_wr_over_ld",0, 0, 0, 1, 7, 1, 12, 0, 12, 0, 0));
    vecs.push_back(mk("mod16_max",     0, 0, 0, 0, 0, 1, 16, 0, 16, 0, 0));
    vecs.push_back(mk("down1_wrap16",  1, 0, 1, 0, 0, 0, 0, 15, 16, 1, 0));

    apply_stimulus(0, 1, '0, 0, '0, 0, '0);
    reset = 1'b0;
    #12;
    check_all("reset", 0, 10, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].en, vecs[i].up, vecs[i].step, vecs[i].load,
                     vecs[i].load_val, vecs[i].mod_wr, vecs[i].mod_val);
      @(posedge clk);
      #1;
      check_all(vecs[i].name, int'(vecs[i].exp_count), int'(vecs[i].exp_mod),
                vecs[i].exp_wrap, vecs[i].exp_err);
    end

    // Asynchronous reset landing between edges while a wrap pulse is high.
    apply_stimulus(0, 0, 0, 0, 0, 1, 5'd10);
    @(posedge clk);
    #1;
    apply_stimulus(0, 0, 0, 1, 4'd5, 0, 0);
    @(posedge clk);
    #1;
    apply_stimulus(1, 1, 4'd9, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("pre_async", 4, 10, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check_all("async_reset", 0, 10, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Modulus write and load together after release: only the modulus moves.
    apply_stimulus(1, 1, 4'd1, 1, 4'd7, 1, 5'd12);
    @(posedge clk);
    #1;
    check_all("post_rst_mod_ld", 0, 12, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
